uart_rx_tx_fifo: RTL

UART_RX_TX_FIFO -- requirements
Module: uart_rx_tx_fifo

---
 rtl/uart_rx_tx_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_rx_tx_fifo.sv
// rtl/uart_rx_tx_fifo.sv - synchronous FIFO with edge/level write qualification, status and sticky error flags
module uart_rx_tx_fifo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned WR_EDGE  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              write_en_q;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic wr_evt, full, empty, wr_acc, rd_acc;

    // Qualify requests against the current-cycle count; flush suppresses everything
    always_comb begin
        wr_evt = (WR_EDGE != 0) ? (write_en & ~write_en_q) : write_en;
        full   = (count_q == DEPTH_C);
        empty  = (count_q == '0);
        wr_acc = wr_evt & ~full & ~flush;
        rd_acc = read_en & ~empty & ~flush;
    end

    // Next-state for pointers, count, read data and sticky flags
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = mem[rd_ptr_q];
            end
            data_valid_d = rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // A set condition in the same cycle as clr_err wins
            if (wr_evt && full)       overflow_d = 1'b1;
            else if (clr_err)         overflow_d = 1'b0;
            if (read_en && empty)     underflow_d = 1'b1;
            else if (clr_err)         underflow_d = 1'b0;
        end
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            write_en_q   <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            write_en_q   <= write_en;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= data_in;
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign fifo_full    = full;
    assign fifo_empty   = empty;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign fill_level   = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
